riscv_v_wb_buffer: RTL and testbench

// - Writeback queue directly downstream of the vector execute ALU stage.
// - Accepts one ALU result per cycle through a valid/ready handshake.
// - Expands the per-element write mask into per-byte enables according to the operand size.
// - Queues results in a DEPTH-entry FIFO and drains them to the VRF write port.
// - Exposes a per-register pending-write vector for decode hazard checks.

---
 rtl/riscv_v_wb_buffer.sv | 141 ++++++++++++++
 tb/tb_riscv_v_wb_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_wb_buffer.sv
// Vector writeback queue: buffers ALU results, expands element masks to byte enables, drains to the VRF.
// Optional zero-latency bypass into an empty queue is enabled by defining RISCV_V_WB_BYPASS_EN.
module riscv_v_wb_buffer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exe_valid,
  output logic                  exe_ready,
  input  logic [ADDR_W-1:0]     exe_vd,
  input  logic [DATA_W-1:0]     exe_data,
  input  logic [DATA_W/8-1:0]   exe_mask,
  input  logic                  exe_masked,
  input  logic [1:0]            exe_osize,
  input  logic                  flush,
  input  logic                  vrf_stall,
  output logic                  vrf_we,
  output logic [ADDR_W-1:0]     vrf_addr,
  output logic [DATA_W-1:0]     vrf_data,
  output logic [DATA_W/8-1:0]   vrf_be,
  output logic [2**ADDR_W-1:0]  pending_vd,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int NREG  = 2 ** ADDR_W;

  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic [ADDR_W-1:0] vd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];

  logic [BE_W-1:0]   be_calc;
  logic              empty;
  logic              full;
  logic              bypass;
  logic              push;
  logic              pop;

  // Byte b belongs to element b >> osize; all selects are constant per byte lane.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
    logic elem_en;
    assign elem_en = (exe_osize == 2'd0) ? exe_mask[gi]   :
                     (exe_osize == 2'd1) ? exe_mask[gi/2] :
                     (exe_osize == 2'd2) ? exe_mask[gi/4] : exe_mask[gi/8];
    assign be_calc[gi] = exe_masked ? elem_en : 1'b1;
  end

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign exe_ready = ~full;

`ifdef RISCV_V_WB_BYPASS_EN
  assign bypass = empty & exe_valid & ~vrf_stall & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign push   = exe_valid & ~full & ~flush & ~bypass;
  assign vrf_we = (~empty | bypass) & ~flush;
  assign pop    = vrf_we & ~vrf_stall & ~empty;

  always_comb begin
    vrf_addr = '0;
    vrf_data = '0;
    vrf_be   = '0;
`ifdef RISCV_V_WB_BYPASS_EN
    if (bypass) begin
      vrf_addr = exe_vd;
      vrf_data = exe_data;
      vrf_be   = be_calc;
    end else
`endif
    if (!empty) begin
      vrf_addr = vd_mem[rd_ptr_reg];
      vrf_data = data_mem[rd_ptr_reg];
      vrf_be   = be_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (vrf_we && vrf_stall && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)
          count_reg <= count_reg + 1'b1;
        else if (pop && !push)
          count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      vd_mem[wr_ptr_reg]   <= exe_vd;
      data_mem[wr_ptr_reg] <= exe_data;
      be_mem[wr_ptr_reg]   <= be_calc;
    end
  end

  assign stall_cnt = stall_cnt_reg;

  // An entry is live when its distance from the read pointer is below the count.
  logic [NREG-1:0] ent_onehot [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PTR_W-1:0] offset;
    logic             live;
    assign offset         = PTR_W'(gi) - rd_ptr_reg;
    assign live           = ({1'b0, offset} < count_reg);
    assign ent_onehot[gi] = live ? (NREG'(1) << vd_mem[gi]) : '0;
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    logic [DEPTH-1:0] hits;
    for (genvar ge = 0; ge < DEPTH; ge++) begin : g_hit
      assign hits[ge] = ent_onehot[ge][gi];
    end
    assign pending_vd[gi] = |hits;
  end

endmodule

// File: tb/tb_riscv_v_wb_buffer.sv
// Self-checking bench for riscv_v_wb_buffer: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_riscv_v_wb_buffer;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int BE_W   = DATA_W / 8;
  localparam int NREG   = 2 ** ADDR_W;
  localparam int CNT_MAX = 2 ** CNT_W - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 exe_valid;
  logic                 exe_ready;
  logic [ADDR_W-1:0]    exe_vd;
  logic [DATA_W-1:0]    exe_data;
  logic [BE_W-1:0]      exe_mask;
  logic                 exe_masked;
  logic [1:0]           exe_osize;
  logic                 flush;
  logic                 vrf_stall;
  logic                 vrf_we;
  logic [ADDR_W-1:0]    vrf_addr;
  logic [DATA_W-1:0]    vrf_data;
  logic [BE_W-1:0]      vrf_be;
  logic [NREG-1:0]      pending_vd;
  logic [CNT_W-1:0]     stall_cnt;

  always #5 clk = ~clk;

  riscv_v_wb_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_vd(exe_vd),
    .exe_data(exe_data), .exe_mask(exe_mask), .exe_masked(exe_masked),
    .exe_osize(exe_osize), .flush(flush), .vrf_stall(vrf_stall),
    .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_data(vrf_data), .vrf_be(vrf_be),
    .pending_vd(pending_vd), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [ADDR_W-1:0] vd;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } ent_t;

  typedef struct {
    logic [ADDR_W-1:0] vd;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   mask;
    logic              masked;
    logic [1:0]        osize;
    logic [BE_W-1:0]   exp_be;
  } vec_t;

  ent_t q[$];
  int   stall_model = 0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Element size is 2**osize bytes; a byte is enabled when its element's mask bit is set.
  function automatic logic [BE_W-1:0] ref_be(input logic [BE_W-1:0] m, input logic masked,
                                             input logic [1:0] os);
    logic [BE_W-1:0] r;
    logic [BE_W-1:0] sh;
    int esz;
    r = '0;
    esz = 1 << os;
    for (int b = 0; b < BE_W; b++) begin
      sh = m >> (b / esz);
      r = (r >> 1) | (BE_W'(masked ? sh[0] : 1'b1) << (BE_W - 1));
    end
    return r;
  endfunction

  task automatic set_exe(input logic v, input logic [ADDR_W-1:0] vd, input logic [DATA_W-1:0] d,
                         input logic [BE_W-1:0] m, input logic msk, input logic [1:0] os);
    exe_valid = v; exe_vd = vd; exe_data = d; exe_mask = m; exe_masked = msk; exe_osize = os;
  endtask

  // One clock: compare all outputs against the model, take the edge, advance the model.
  task automatic step();
    logic byp;
    logic exp_we;
    logic push_ok;
    ent_t h;
    logic [NREG-1:0] pend;
    #1;
    byp = 1'b0;
`ifdef RISCV_V_WB_BYPASS_EN
    byp = (q.size() == 0) && exe_valid && !vrf_stall && !flush;
`endif
    exp_we  = (q.size() != 0 || byp) && !flush;
    push_ok = exe_valid && (q.size() != DEPTH) && !flush && !byp;
    chk("exe_ready", exe_ready, q.size() != DEPTH);
    chk("vrf_we", vrf_we, exp_we);
    h = '{'0, '0, '0};
    if (exp_we) begin
      if (byp) h = '{exe_vd, exe_data, ref_be(exe_mask, exe_masked, exe_osize)};
      else     h = q[0];
      chk("vrf_addr", vrf_addr, h.vd);
      chk("vrf_data", vrf_data, h.data);
      chk("vrf_be", vrf_be, h.be);
    end
    pend = '0;
    foreach (q[i]) pend |= NREG'(1) << q[i].vd;
    chk("pending_vd", pending_vd, pend);
    chk("stall_cnt", stall_cnt, stall_model);
    @(posedge clk);
    if (exp_we && vrf_stall && stall_model < CNT_MAX) stall_model++;
    if (exp_we && !vrf_stall) begin
      $display("write vr%0d data=%h be=%h", h.vd, h.data, h.be);
      if (!byp) void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (push_ok) q.push_back('{exe_vd, exe_data, ref_be(exe_mask, exe_masked, exe_osize)});
    #1;
  endtask

  task automatic chk_vec(input int i);
    chk("tbl_we", vrf_we, 1'b1);
    chk("tbl_addr", vrf_addr, vecs[i].vd);
    chk("tbl_data", vrf_data, vecs[i].data);
    chk("tbl_be", vrf_be, vecs[i].exp_be);
  endtask

  initial begin
    vecs[0] = '{5'd3,  {16{8'hA5}},         16'h1234, 1'b0, 2'd0, 16'hFFFF};
    vecs[1] = '{5'd7,  {4{32'h1111_0001}},  16'h0005, 1'b1, 2'd2, 16'h0F0F};
    vecs[2] = '{5'd9,  {4{32'h2222_0002}},  16'h8001, 1'b1, 2'd0, 16'h8001};
    vecs[3] = '{5'd12, {4{32'h3333_0003}},  16'h00A5, 1'b1, 2'd1, 16'hCC33};
    vecs[4] = '{5'd31, {4{32'h4444_0004}},  16'h0002, 1'b1, 2'd3, 16'hFF00};
    vecs[5] = '{5'd0,  {4{32'h5555_0005}},  16'hFFFC, 1'b1, 2'd3, 16'h0000};
    vecs[6] = '{5'd16, {4{32'h6666_0006}},  16'h0008, 1'b1, 2'd2, 16'hF000};
    vecs[7] = '{5'd21, {4{32'h7777_0007}},  16'h0000, 1'b1, 2'd0, 16'h0000};

    rst = 1'b1; flush = 1'b0; vrf_stall = 1'b0;
    set_exe(1'b0, '0, '0, '0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", exe_ready, 1'b1);
    chk("rst_we", vrf_we, 1'b0);
    chk("rst_addr", vrf_addr, '0);
    chk("rst_data", vrf_data, '0);
    chk("rst_be", vrf_be, '0);
    chk("rst_pending", pending_vd, '0);
    chk("rst_stall_cnt", stall_cnt, '0);

    // Table vectors: each pushed into an empty buffer and observed at the write port.
    for (int i = 0; i < 8; i++) begin
      set_exe(1'b1, vecs[i].vd, vecs[i].data, vecs[i].mask, vecs[i].masked, vecs[i].osize);
`ifdef RISCV_V_WB_BYPASS_EN
      #1 chk_vec(i);
      step();
      exe_valid = 1'b0;
`else
      step();
      exe_valid = 1'b0;
      #1 chk_vec(i);
      chk("tbl_pending_set", pending_vd, NREG'(1) << vecs[i].vd);
      step();
      #1 chk("tbl_pending_clr", pending_vd, '0);
`endif
    end

    // Fill under stall, confirm full, then drain in order.
    vrf_stall = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      set_exe(1'b1, ADDR_W'(10 + k), DATA_W'(k + 1), '0, 1'b0, 2'd0);
      step();
    end
    exe_valid = 1'b0;
    #1 chk("full_ready", exe_ready, 1'b0);
    chk("full_stall_cnt", stall_cnt, 4'd3);
    set_exe(1'b1, 5'd30, DATA_W'(99), '0, 1'b0, 2'd0);
    step();
    vrf_stall = 1'b0;
    #1 chk("pop_no_reopen", exe_ready, 1'b0);
    step();
    exe_valid = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      #1 chk("drain_order", vrf_addr, ADDR_W'(10 + k));
      step();
    end
    #1 chk("drain_done_we", vrf_we, 1'b0);
    chk("drain_stall_cnt", stall_cnt, 4'd4);

    // Steady push+pop: occupancy stays at one entry while pointers wrap.
    set_exe(1'b1, 5'd1, DATA_W'(100), '0, 1'b0, 2'd0);
    step();
    for (int k = 0; k < 10; k++) begin
      set_exe(1'b1, ADDR_W'(k + 2), DATA_W'(k + 101), '0, 1'b0, 2'd0);
      #1;
`ifdef RISCV_V_WB_BYPASS_EN
      chk("steady_addr", vrf_addr, ADDR_W'(k + 2));
`else
      chk("steady_addr", vrf_addr, ADDR_W'(k + 1));
      chk("steady_pending", pending_vd, NREG'(1) << (k + 1));
`endif
      chk("steady_ready", exe_ready, 1'b1);
      step();
    end
    exe_valid = 1'b0;
    step();
    #1 chk("steady_empty_we", vrf_we, 1'b0);

    // Flush with three queued entries plus a concurrent push.
    vrf_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_exe(1'b1, ADDR_W'(20 + k), DATA_W'(200 + k), '0, 1'b0, 2'd0);
      step();
    end
    set_exe(1'b1, 5'd23, DATA_W'(203), '0, 1'b0, 2'd0);
    flush = 1'b1;
    #1 chk("flush_we_gated", vrf_we, 1'b0);
    step();
    flush = 1'b0; exe_valid = 1'b0; vrf_stall = 1'b0;
    #1 chk("flush_we", vrf_we, 1'b0);
    chk("flush_pending", pending_vd, '0);
    chk("flush_ready", exe_ready, 1'b1);
    chk("flush_stall_cnt", stall_cnt, 4'd6);
    step();

    // Randomized traffic against the model, with one asynchronous reset mid-run.
    for (int c = 0; c < 1500; c++) begin
      set_exe(($urandom % 3) != 0, ADDR_W'($urandom), {$urandom, $urandom, $urandom, $urandom},
              BE_W'($urandom), 1'($urandom), 2'($urandom));
      vrf_stall = ($urandom % 4) == 0;
      flush     = ($urandom % 40) == 0;
      if (c == 700) begin
        exe_valid = 1'b0; flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_we", vrf_we, 1'b0);
        chk("arst_pending", pending_vd, '0);
        chk("arst_stall_cnt", stall_cnt, '0);
        chk("arst_ready", exe_ready, 1'b1);
        rst = 1'b0;
        q.delete();
        stall_model = 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
